// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and byte type
//
// Purpose : constants and types shared by the UART receiver, the receive
//           FIFO and the future transmitter.
// Contents: UART_DATA_W                  - byte width (8)
//           UART_FIFO_DEPTH_LOG2_DEFAULT - default FIFO depth exponent (4 -> 16)
//           UART_DROP_COUNT_W            - width of the dropped-byte counter
//           uart_byte_t                  - one UART byte
//           uart_sat_inc                 - saturating increment helper

package uart_pkg;

  localparam int UART_DATA_W                  = 8;
  localparam int UART_FIFO_DEPTH_LOG2_DEFAULT = 4;
  localparam int UART_DROP_COUNT_W            = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UART_DROP_COUNT_W-1:0] uart_sat_inc(
    input logic [UART_DROP_COUNT_W-1:0] value
  );
    if (&value) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - FIFO storage array with async read
//
// Purpose : 2^ADDR_W x DATA_W register array. One synchronous write port and
//           one asynchronous (combinational) read port. Contents are not
//           reset; the owner tracks which entries are valid.
// Ports   : i_clk      - system clock
//           i_wr_en    - write strobe, sampled on rising edge
//           i_wr_addr  - write address
//           i_wr_data  - write data
//           i_rd_addr  - read address
//           o_rd_data  - data stored at i_rd_addr (combinational)

module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO behind the UART receiver
//
// Purpose : captures each byte from the UART receiver (pulse or level-held
//           valid, one push per rising edge of valid), acknowledges it with a
//           one-cycle i_rx_read_en pulse, buffers it and hands it downstream
//           through a valid/ready port. Pushes into a full FIFO are dropped
//           unless a pop happens on the same edge.
// Options : UART_RX_FIFO_OVERFLOW_STATUS_EN - when defined, o_overflow is a
//           sticky drop flag and o_drop_count a saturating drop counter;
//           otherwise both are tied to 0.
// Ports   : i_clk        - system clock
//           i_reset      - asynchronous active-high reset
//           i_rx_data    - byte from the receiver
//           i_rx_valid   - receiver valid (pulse or level)
//           o_rx_read_en - one-cycle acknowledge to the receiver
//           i_clear      - synchronous flush
//           o_m_data     - head byte, 0 when o_m_valid is low
//           o_m_valid    - FIFO non-empty
//           i_m_ready    - consumer pops head when o_m_valid && i_m_ready
//           o_fill_level - stored byte count, 0..2^DEPTH_LOG2
//           o_overflow   - sticky drop flag (option)
//           o_drop_count - saturating dropped-byte count (option)

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [DATA_W-1:0]            i_rx_data,
  input  logic                         i_rx_valid,
  output logic                         o_rx_read_en,
  input  logic                         i_clear,
  output logic [DATA_W-1:0]            o_m_data,
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic [DEPTH_LOG2:0]          o_fill_level,
  output logic                         o_overflow,
  output logic [UART_DROP_COUNT_W-1:0] o_drop_count
);

  // Fill level that means "every slot occupied".
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  r_rx_valid_d;
  logic                  r_rx_read_en;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_fill_level;

  logic                  w_push_req;
  logic                  w_full;
  logic                  w_m_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_mem_we;
  logic [DATA_W-1:0]     w_rd_data;

  // A rising edge of valid is one byte, so a receiver that holds valid until
  // acknowledged is not pushed twice.
  assign w_push_req = i_rx_valid & ~r_rx_valid_d;

  assign w_full    = (r_fill_level == FULL_LEVEL);
  assign w_m_valid = (r_fill_level != '0);

  // Pop is only meaningful with data present; i_m_ready is ignored when empty.
  assign w_pop  = w_m_valid & i_m_ready;

  // When full, a same-edge pop frees the slot the push lands in (wr == rd).
  assign w_push = w_push_req & (~w_full | w_pop);

  // Flush discards a simultaneous push; the acknowledge still goes out.
  assign w_mem_we = w_push & ~i_clear;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_rx_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_valid_d <= 1'b0;
      r_rx_read_en <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
    end else begin
      r_rx_valid_d <= i_rx_valid;
      // Acknowledge every detected byte, stored or not.
      r_rx_read_en <= w_push_req;

      if (i_clear) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_fill_level <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_fill_level <= r_fill_level + 1'b1;
          2'b01:   r_fill_level <= r_fill_level - 1'b1;
          default: r_fill_level <= r_fill_level;
        endcase
      end
    end
  end

  assign o_rx_read_en = r_rx_read_en;
  assign o_m_valid    = w_m_valid;
  assign o_m_data     = w_m_valid ? w_rd_data : '0;
  assign o_fill_level = r_fill_level;

`ifdef UART_RX_FIFO_OVERFLOW_STATUS_EN
  logic                         r_overflow;
  logic [UART_DROP_COUNT_W-1:0] r_drop_count;
  logic                         w_drop;

  // A byte is lost only when full and the same edge does not pop.
  assign w_drop = w_push_req & w_full & ~w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (i_clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= uart_sat_inc(r_drop_count);
    end
  end

  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;
`else
  assign o_overflow   = 1'b0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo

module tb_uart_rx_fifo;
  import uart_pkg::*;

`ifdef UART_RX_FIFO_OVERFLOW_STATUS_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  uart_byte_t rx_data;
  logic       rx_valid;
  logic       rx_read_en;
  logic       clear;
  uart_byte_t m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] fill_level;
  logic       overflow;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_read_en (rx_read_en),
    .i_clear      (clear),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_fill_level (fill_level),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       m_ready;
    logic       clear;
    logic       exp_read_en;
    logic       exp_m_valid;
    logic [7:0] exp_m_data;
    logic [4:0] exp_fill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [7:0] d, input logic rdy, input logic clr,
                     input logic er, input logic ev, input logic [7:0] ed, input logic [4:0] ef);
    vec_t v;
    v.rx_valid = rv; v.rx_data = d; v.m_ready = rdy; v.clear = clr;
    v.exp_read_en = er; v.exp_m_valid = ev; v.exp_m_data = ed; v.exp_fill = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string name, input logic [7:0] d);
    chk({name, "_valid"}, 32'(m_valid), 32'd1);
    chk({name, "_data"}, 32'(m_data), 32'(d));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; clear = 1'b0; m_ready = 1'b0;

    // Single byte, level-held valid, push+pop with one entry, flush with push,
    // empty-FIFO ready ignored, no same-cycle pop of a byte pushed into empty.
    add(1'b1, 8'hA5, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA5, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 8'hA5, 5'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 8'h00, 5'd0);
    add(1'b1, 8'h3C, 1'b0, 1'b0,  1'b1, 1'b1, 8'h3C, 5'd1);
    for (int i = 0; i < 9; i++)
      add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 8'h3C, 5'd1);
    add(1'b1, 8'h11, 1'b1, 1'b0,  1'b1, 1'b1, 8'h11, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 8'h11, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 5'd0);
    add(1'b1, 8'h22, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 5'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b0, 8'h00, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 8'h00, 5'd0);
    add(1'b1, 8'h44, 1'b1, 1'b0,  1'b1, 1'b1, 8'h44, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 8'h44, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 5'd0);

    tick();
    tick();
    chk("rst_read_en", 32'(rx_read_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      rx_valid = vecs[i].rx_valid;
      rx_data  = vecs[i].rx_data;
      m_ready  = vecs[i].m_ready;
      clear    = vecs[i].clear;
      tick();
      chk($sformatf("vec%0d_read_en", i), 32'(rx_read_en), 32'(vecs[i].exp_read_en));
      chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].exp_m_valid));
      chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].exp_m_data));
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
    end
    rx_valid = 1'b0; m_ready = 1'b0; clear = 1'b0;
    tick();

    // Fill and wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill16", 32'(fill_level), 32'd16);
    for (int i = 0; i < 8; i++) pop_check($sformatf("popA%0d", i), 8'(i));
    for (int i = 0; i < 8; i++) push_byte(8'(16 + i));
    chk("fill16_wrap", 32'(fill_level), 32'd16);

    // Full push with same-edge pop: both accepted.
    chk("fullpp_head", 32'(m_data), 32'h08);
    rx_valid = 1'b1; rx_data = 8'h55; m_ready = 1'b1;
    tick();
    chk("fullpp_read_en", 32'(rx_read_en), 32'd1);
    chk("fullpp_fill", 32'(fill_level), 32'd16);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    chk("fullpp_drop", 32'(drop_count), 32'd0);
    rx_valid = 1'b0; m_ready = 1'b0;
    tick();
    for (int i = 9; i < 24; i++) pop_check($sformatf("popB%0d", i), 8'(i));
    pop_check("popB_last", 8'h55);
    chk("drained_valid", 32'(m_valid), 32'd0);
    chk("drained_data", 32'(m_data), 32'd0);
    chk("drained_fill", 32'(fill_level), 32'd0);

    // Overflow: 17th byte dropped but acknowledged, head not corrupted.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    chk("drop_read_en", 32'(rx_read_en), 32'd1);
    chk("drop_fill", 32'(fill_level), 32'd16);
    rx_valid = 1'b0;
    tick();
    chk("drop_overflow", 32'(overflow), 32'(OVF_EN));
    chk("drop_count1", 32'(drop_count), OVF_EN ? 32'd1 : 32'd0);
    chk("drop_head", 32'(m_data), 32'h80);
    for (int i = 0; i < 259; i++) push_byte(8'hEE);
    chk("drop_sat", 32'(drop_count), OVF_EN ? 32'd255 : 32'd0);
    chk("drop_sat_fill", 32'(fill_level), 32'd16);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_fill", 32'(fill_level), 32'd0);
    chk("clr_valid", 32'(m_valid), 32'd0);
    chk("clr_data", 32'(m_data), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Reset asserted between edges, released with valid still high.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    chk("pre_rst_fill", 32'(fill_level), 32'd5);
    #3;
    reset = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h77;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_fill", 32'(fill_level), 32'd0);
    tick();
    #2;
    reset = 1'b0;
    tick();
    chk("rel_read_en", 32'(rx_read_en), 32'd1);
    chk("rel_fill", 32'(fill_level), 32'd1);
    chk("rel_data", 32'(m_data), 32'h77);
    tick();
    chk("rel_read_en2", 32'(rx_read_en), 32'd0);
    chk("rel_fill2", 32'(fill_level), 32'd1);
    rx_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO directly downstream of the UART receiver. Each byte the receiver presents on `rx_data`/`rx_valid` is captured and acknowledged with a one-cycle `rx_read_en` pulse. Bytes are buffered in a first-word-fall-through queue. Downstream consumers (command parser, LCD writer) drain the queue through a valid/ready port, so a slow I2C/LCD path never loses UART bytes until the buffer is full.

## Interface
- `DATA_W`, 8: byte width.
- `DEPTH_LOG2`, 4: log2 of entry count (default 16 entries); legal 2..8.
- `clk` in 1: system clock (1 MHz in this design).
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in DATA_W: byte from the UART receiver.
- `rx_valid` in 1: receiver data valid. May be a one-cycle pulse or a level held until acknowledged.
- `rx_read_en` out 1: one-cycle acknowledge to the receiver.
- `clear` in 1: synchronous flush.
- `m_data` out DATA_W: head byte; 0 when `m_valid`=0.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer pops head when `m_valid`&&`m_ready`.
- `fill_level` out DEPTH_LOG2+1: number of stored bytes, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky drop flag (only with macro).
- `drop_count` out 8: dropped-byte counter (only with macro).

## Operation
- Push detect: `rx_valid_d` registers `rx_valid`. Push request = `rx_valid` & ~`rx_valid_d`. This accepts both the pulse and level-held forms with exactly one push per byte.
- Push edge: `rx_data` is written at `wr_ptr` and `wr_ptr` increments, both on the push-request edge. `rx_read_en`=1 for exactly the following cycle, whether or not the byte was stored.
- Pop: on an edge with `m_valid`&&`m_ready`, `rd_ptr` increments.
- Pointers are DEPTH_LOG2 wide and wrap modulo 2^DEPTH_LOG2. `fill_level` is a separate counter: +1 push, −1 pop, unchanged for push+pop.
- Full: fill_level == 2^DEPTH_LOG2.
  - Push while full and no pop in the same cycle: byte dropped, pointers and count unchanged.
  - Push while full with a pop in the same cycle: both accepted (pop frees the slot first).
- Empty: `m_valid`=0, `m_data`=0, `m_ready` ignored. A push into an empty FIFO cannot pop in the same cycle.
- `clear`: on the edge where it is 1, pointers, count, `overflow` and `drop_count` go to 0.
  - A simultaneous push is discarded but still acknowledged.
  - A simultaneous pop is ignored.
- Reset: `rx_valid_d`=0, `rx_read_en`=0, pointers=0, `fill_level`=0, `m_valid`=0, `m_data`=0, `overflow`=0, `drop_count`=0. Memory contents are not reset.
- Reset asserted mid-operation: all stored bytes are lost. If `rx_valid` is still high when reset releases, `rx_valid_d`=0 causes one push on the first edge after release.

## Timing
- Push latency: request seen at edge N → `rx_read_en` high in cycle N..N+1. `m_valid` and `fill_level` updated after edge N, so a byte pushed into an empty FIFO is visible one cycle after the receiver's valid is sampled.
- `m_data` is combinational from memory at `rd_ptr`, gated by `m_valid`. It is stable while `m_valid`&&!`m_ready`.
- Pop takes effect at the edge; the next head appears the same cycle after that edge.
- A back-to-back push every cycle is impossible because a rising edge is needed; the maximum push rate is one per 2 cycles. This is far above 9600 baud.

## Configuration
- `UART_RX_FIFO_OVERFLOW_STATUS_EN` defined:
  - `overflow` is set on any dropped push and held until `clear` or `reset`.
  - `drop_count` increments per dropped byte and saturates at 255.
- Macro undefined:
  - `overflow` and `drop_count` tie to 0 and carry no logic.
  - Drop behaviour itself is identical.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W` = 8, `UART_FIFO_DEPTH_LOG2_DEFAULT` = 4, and a `uart_byte_t` typedef. These are shared with the receiver and the future transmitter.
- One sub-module, `uart_fifo_mem`: DEPTH×DATA_W register array with write port and asynchronous read port. Push detect, pointers, counters and flags stay in `uart_rx_fifo`.

## Test plan
- Single byte: reset, then `rx_valid` pulse with `rx_data`=8'hA5 → `rx_read_en` one cycle, `m_valid`=1, `m_data`=8'hA5, `fill_level`=1. Pop with `m_ready`=1 → `m_valid`=0, `m_data`=0.
- Level-held valid: hold `rx_valid`=1 for 10 cycles with 8'h3C → exactly one push and one `rx_read_en` pulse, `fill_level`=1.
- Fill and wrap: push 0x00..0x0F (16 bytes) → `fill_level`=16. Pop 8, push 0x10..0x17, pop 16 → bytes arrive in order 0x08..0x17.
- Overflow (macro on): push 17 bytes with no pops → 17th byte dropped but acknowledged, `overflow`=1, `drop_count`=1, `fill_level`=16. `clear` → all zero.
- Full push+pop: with FIFO full, push 8'h55 with `m_valid`&&`m_ready` in the same cycle → `fill_level` stays 16, no drop, 8'h55 is the last byte out.
- Reset mid-stream: 5 bytes stored, assert `reset` asynchronously between edges → `m_valid`=0 and `fill_level`=0 immediately. With `rx_valid` high at release → one push on the first edge after release.
